rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//  Parametrised N-input registered multiplexer with valid/ready handshake and
//  built-in arbitration. It replaces fixed-select muxing wherever several
//  producers share one consumer, e.g. bus-master or register-file write-back
//  merging. It selects one requesting channel per cycle, round-robin or fixed
//  priority, and registers that channel's word and index onto one output port.
// PARAMETERS
//  WIDTH  8  data width per channel, >= 1
//  N_IN   4  number of input channels, >= 2 (need not be a power of 2)
//  MODE   0  0 = round-robin arbitration; 1 = fixed priority, lowest index wins
//  SEL_W  derived localparam = max(1, clog2(N_IN)); width of out_sel
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  in_data    in   N_IN*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N_IN         channel i has a word to send
//  in_ready   out  N_IN         channel i word accepted this cycle
//  out_data   out  WIDTH        registered selected word
//  out_sel    out  SEL_W        index of the channel that produced out_data
//  out_valid  out  1            out_data/out_sel hold a word
//  out_ready  in   1            consumer accepts the word this cycle
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. rst_n low forces
//    out_valid=0, out_data=0, out_sel=0 and the priority pointer ptr=0
//    immediately, without waiting for a clock edge. Any held word is dropped.
//  - in_ready is combinational from state and inputs. It is all-zero during reset.
//  - load_en = !out_valid | out_ready. The output register accepts a new word
//    when it is empty or is being drained in the same cycle.
//  - Grant, MODE=0: the first i with in_valid[i]=1, scanning ptr, ptr+1, ...,
//    N_IN-1, 0, ... ptr-1. Indices wrap modulo N_IN explicitly; no 2^k wrap.
//  - Grant, MODE=1: the lowest i with in_valid[i]=1. ptr is unused and held at 0.
//  - in_ready[g] = load_en & in_valid[g] for the granted index g only. Every
//    other in_ready bit is 0. At most one in_ready bit is high per cycle.
//  - Transfer edge (load_en and some in_valid set):
//      out_data <= word of channel g
//      out_sel  <= g
//      out_valid <= 1
//      MODE=0 only: ptr <= (g == N_IN-1) ? 0 : g+1
//  - load_en with no in_valid set: out_valid <= 0. out_data, out_sel and ptr
//    hold their values.
//  - Stall (out_valid=1, out_ready=0): out_data, out_sel, out_valid and ptr
//    hold, and all in_ready bits are 0.
//  - Latency: a word accepted at edge k appears on the output after edge k.
//  - Throughput: 1 word per cycle while out_ready stays high.
//  - out_ready while out_valid=0 is ignored and has no side effects.
//  - in_valid may change on any cycle. Only the cycle's combinational grant matters.
//  - No word is ever duplicated or lost outside of reset.
// TESTING
//  1 Reset: assert rst_n=0 mid-cycle -> out_valid=0, out_data=0, out_sel=0 and
//    in_ready=0 immediately, before the next clk edge.
//  2 RR sweep (MODE=0, N_IN=4): all valid, data A0..A3, out_ready=1 -> output
//    sequence A0,A1,A2,A3,A0 on consecutive cycles, out_sel 0,1,2,3,0.
//  3 Backpressure: out_valid=1, hold out_ready=0 for 3 cycles -> out_data and
//    out_sel stable, in_ready=4'b0000. Release -> next word follows 1 cycle later.
//  4 Wrap/sparse: after a grant of ch3, only ch1 valid -> ptr=0, ch1 granted,
//    out_sel=1, then ptr=2.
//  5 Fixed priority (MODE=1): ch0 and ch3 valid continuously -> ch0 granted
//    every cycle, in_ready[3] never high. Drop ch0 -> ch3 granted the next cycle.
//  6 Non-power-of-2 (N_IN=3, WIDTH=16): all valid -> out_sel 0,1,2,0, never 3.
//    Scoreboard confirms every word is delivered exactly once.

Source files
------------

// File: rtl/rr_arb_mux.sv
// N-input registered mux with a valid/ready handshake and round-robin or fixed-priority arbitration.
// Each channel has its own lane instance that gates its word and ready onto the shared path.

module rr_arb_mux_lane #(
  parameter int WIDTH = 8
) (
  input  logic             gnt,
  input  logic             load_en,
  input  logic             vld,
  input  logic [WIDTH-1:0] data,
  output logic             rdy,
  output logic [WIDTH-1:0] data_m
);
  assign rdy    = gnt & load_en & vld;
  assign data_m = gnt ? data : '0;
endmodule

module rr_arb_mux #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int MODE  = 0,
  localparam int SEL_W = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);
  logic [WIDTH-1:0]            out_data_q, out_data_d;
  logic [SEL_W-1:0]            out_sel_q, out_sel_d;
  logic                        out_valid_q, out_valid_d;
  logic [SEL_W-1:0]            ptr_q, ptr_d;

  logic                        load_en, lane_en, any_vld;
  logic [SEL_W-1:0]            gnt_idx;
  logic [N_IN-1:0]             gnt_oh;
  logic [N_IN-1:0][WIDTH-1:0]  lane_data;
  logic [WIDTH-1:0]            mux_data;

  assign load_en = !out_valid_q | out_ready;
  // Reset also clears in_ready, since an empty output register would otherwise look loadable.
  assign lane_en = load_en & rst_n;
  assign any_vld = |in_valid;

  always_comb begin
    int  idx;
    logic found;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (MODE == 1) begin
      for (int i = N_IN - 1; i >= 0; i--)
        if (in_valid[i]) gnt_idx = SEL_W'(i);
    end else begin
      // Scan from ptr with an explicit modulo-N_IN wrap so non-power-of-2 N_IN works.
      for (int k = 0; k < N_IN; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N_IN) idx = idx - N_IN;
        if (!found && in_valid[idx]) begin
          found   = 1'b1;
          gnt_idx = SEL_W'(idx);
        end
      end
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    assign gnt_oh[i] = any_vld && (gnt_idx == SEL_W'(i));
    rr_arb_mux_lane #(.WIDTH(WIDTH)) u_lane (
      .gnt     (gnt_oh[i]),
      .load_en (lane_en),
      .vld     (in_valid[i]),
      .data    (in_data[i*WIDTH +: WIDTH]),
      .rdy     (in_ready[i]),
      .data_m  (lane_data[i])
    );
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N_IN; i++) mux_data = mux_data | lane_data[i];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = any_vld;
      if (any_vld) begin
        out_data_d = mux_data;
        out_sel_d  = gnt_idx;
        if (MODE == 0)
          ptr_d = (gnt_idx == SEL_W'(N_IN - 1)) ? '0 : SEL_W'(gnt_idx + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: round-robin 4-input, fixed-priority 4-input, round-robin 3-input x16.
module tb_rr_arb_mux;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // A: MODE 0, N_IN 4, WIDTH 8
  logic [31:0] a_data;
  logic [3:0]  a_valid, a_ready;
  logic [7:0]  a_odata;
  logic [1:0]  a_osel;
  logic        a_ovalid, a_oready;
  // B: MODE 1, N_IN 4, WIDTH 8
  logic [31:0] b_data;
  logic [3:0]  b_valid, b_ready;
  logic [7:0]  b_odata;
  logic [1:0]  b_osel;
  logic        b_ovalid, b_oready;
  // C: MODE 0, N_IN 3, WIDTH 16
  logic [47:0] c_data;
  logic [2:0]  c_valid, c_ready;
  logic [15:0] c_odata;
  logic [1:0]  c_osel;
  logic        c_ovalid, c_oready;

  rr_arb_mux #(.WIDTH(8), .N_IN(4), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out_data(a_odata), .out_sel(a_osel), .out_valid(a_ovalid), .out_ready(a_oready));
  rr_arb_mux #(.WIDTH(8), .N_IN(4), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out_data(b_odata), .out_sel(b_osel), .out_valid(b_ovalid), .out_ready(b_oready));
  rr_arb_mux #(.WIDTH(16), .N_IN(3), .MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .out_data(c_odata), .out_sel(c_osel), .out_valid(c_ovalid), .out_ready(c_oready));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  a_seq_d [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
  logic [1:0]  a_seq_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0]  a_seq_r [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int          c_cnt [3];
  logic [15:0] c_word;

  initial begin
    rst_n = 1'b0;
    a_data = 32'hA3A2A1A0; a_valid = '0; a_oready = 1'b0;
    b_data = 32'hB3B2B1B0; b_valid = '0; b_oready = 1'b0;
    c_data = '0;           c_valid = '0; c_oready = 1'b0;
    #1;
    chk("rst_a_valid", 32'(a_ovalid), 32'd0);
    chk("rst_a_data",  32'(a_odata),  32'd0);
    chk("rst_a_sel",   32'(a_osel),   32'd0);
    chk("rst_b_valid", 32'(b_ovalid), 32'd0);
    chk("rst_c_valid", 32'(c_ovalid), 32'd0);
    a_valid = 4'hF;
    #1;
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    tick();
    rst_n = 1'b1;

    // Round-robin sweep
    a_oready = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1 chk($sformatf("rr_ready%0d", s), 32'(a_ready), 32'(a_seq_r[s]));
      tick();
      chk($sformatf("rr_data%0d", s), 32'(a_odata), 32'(a_seq_d[s]));
      chk($sformatf("rr_sel%0d", s),  32'(a_osel),  32'(a_seq_s[s]));
      chk($sformatf("rr_vld%0d", s),  32'(a_ovalid), 32'd1);
    end

    // Backpressure: hold A0/sel0 for three cycles
    a_oready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1 chk("bp_ready", 32'(a_ready), 32'd0);
      tick();
      chk("bp_data", 32'(a_odata), 32'hA0);
      chk("bp_sel",  32'(a_osel),  32'd0);
      chk("bp_vld",  32'(a_ovalid), 32'd1);
    end
    a_oready = 1'b1;
    #1 chk("bp_rel_ready", 32'(a_ready), 32'b0010);
    tick();
    chk("bp_rel_data", 32'(a_odata), 32'hA1);
    chk("bp_rel_sel",  32'(a_osel),  32'd1);

    // Wrap/sparse: grant ch3, then only ch1 -> ptr wraps to 0, then lands at 2
    a_valid = 4'b1000;
    tick();
    chk("wrap_sel3", 32'(a_osel), 32'd3);
    a_valid = 4'b0010;
    #1 chk("wrap_ready1", 32'(a_ready), 32'b0010);
    tick();
    chk("wrap_sel1",  32'(a_osel),  32'd1);
    chk("wrap_data1", 32'(a_odata), 32'hA1);
    a_valid = 4'hF;
    #1 chk("wrap_ptr2", 32'(a_ready), 32'b0100);

    // Nothing valid: output empties but data/sel hold
    a_valid = 4'b0000;
    tick();
    chk("idle_vld",  32'(a_ovalid), 32'd0);
    chk("idle_data", 32'(a_odata),  32'hA1);
    chk("idle_sel",  32'(a_osel),   32'd1);
    tick();
    chk("idle_vld2", 32'(a_ovalid), 32'd0);

    // Mid-cycle async reset drops a held word without a clock edge
    a_valid = 4'b1000;
    tick();
    chk("pre_rst_vld", 32'(a_ovalid), 32'd1);
    a_oready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",   32'(a_ovalid), 32'd0);
    chk("mid_rst_data",  32'(a_odata),  32'd0);
    chk("mid_rst_sel",   32'(a_osel),   32'd0);
    chk("mid_rst_ready", 32'(a_ready),  32'd0);
    a_valid = '0;
    tick();
    rst_n = 1'b1;

    // Fixed priority: ch0 and ch3 valid, ch0 always wins
    b_valid = 4'b1001; b_oready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      #1 chk("fp_ready", 32'(b_ready), 32'b0001);
      tick();
      chk("fp_sel",  32'(b_osel),  32'd0);
      chk("fp_data", 32'(b_odata), 32'hB0);
    end
    b_valid = 4'b1000;
    #1 chk("fp_ready3", 32'(b_ready), 32'b1000);
    tick();
    chk("fp_sel3",  32'(b_osel),  32'd3);
    chk("fp_data3", 32'(b_odata), 32'hB3);
    b_valid = 4'b1001;
    #1 chk("fp_ptr_unused", 32'(b_ready), 32'b0001);

    // N_IN=3: sel cycles 0,1,2,0,...; each channel offers a fresh word per acceptance
    c_cnt = '{0, 0, 0};
    c_valid = 3'b111; c_oready = 1'b1;
    for (int s = 0; s < 7; s++) begin
      for (int i = 0; i < 3; i++)
        c_data[i*16 +: 16] = {4'(i + 1), 12'(c_cnt[i])};
      c_word = {4'((s % 3) + 1), 12'(c_cnt[s % 3])};
      #1 chk($sformatf("n3_ready%0d", s), 32'(c_ready), 32'(3'b001 << (s % 3)));
      tick();
      chk($sformatf("n3_sel%0d", s),  32'(c_osel),  32'(s % 3));
      chk($sformatf("n3_data%0d", s), 32'(c_odata), 32'(c_word));
      c_cnt[s % 3]++;
    end
    c_valid = '0;
    tick();
    chk("n3_drain", 32'(c_ovalid), 32'd0);
    chk("n3_cnt0", 32'(c_cnt[0]), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
